// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches words from instruction memory, runs NOP/HALT/JUMP/REPEAT
// internally and hands compute opcodes to the datapath. Define INST_SEQ_REPEAT_EN for nested REPEAT.
module inst_sequencer #(
  parameter int INST_W     = 32,
  parameter int OPCODE_W   = 4,
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 16,
  parameter int BODY_W     = 8,
  parameter int LOOP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              dispatch_valid,
  output logic [INST_W-1:0] dispatch_inst,
  input  logic              dispatch_ready,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_HALTED   = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_NOP          = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LAST_COMPUTE = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_HALT         = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JUMP         = OPCODE_W'(11);
  localparam logic [ADDR_W-1:0]   PC_ONE          = ADDR_W'(1);

  if ((ADDR_W > INST_W - OPCODE_W) || (CNT_W + BODY_W > INST_W - OPCODE_W) || (LOOP_DEPTH < 1))
  begin : g_bad_cfg
    $error("inst_sequencer: operand fields do not fit the instruction word");
  end

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   pc_s;
  logic [ADDR_W-1:0]   adv_pc_s;
  logic                latch_s;
  logic [OPCODE_W-1:0] opcode_s;

  assign opcode_s = imem_rdata[INST_W-1 -: OPCODE_W];

`ifdef INST_SEQ_REPEAT_EN
  localparam int              SP_W    = $clog2(LOOP_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OPCODE_W-1:0] OP_REPEAT = OPCODE_W'(10);

  logic [ADDR_W-1:0] lp_start_r [LOOP_DEPTH];
  logic [ADDR_W-1:0] lp_end_r   [LOOP_DEPTH];
  logic [CNT_W-1:0]  lp_rem_r   [LOOP_DEPTH];
  logic [SP_W-1:0]   sp_r;
  logic [SP_W-1:0]   top_idx_s;
  logic              top_valid_s;
  logic              stack_full_s;
  logic [ADDR_W-1:0] top_start_s;
  logic [ADDR_W-1:0] top_end_s;
  logic [CNT_W-1:0]  top_rem_s;
  logic              adv_pop_s;
  logic              adv_dec_s;
  logic              advance_s;
  logic              clear_s;
  logic              push_s;
  logic [CNT_W-1:0]  rep_cnt_s;
  logic [BODY_W-1:0] rep_len_s;
  logic [ADDR_W-1:0] push_end_s;

  assign top_idx_s    = sp_r - SP_ONE;
  assign top_valid_s  = (sp_r != {SP_W{1'b0}});
  assign stack_full_s = (sp_r == SP_W'(LOOP_DEPTH));
  assign rep_cnt_s    = imem_rdata[CNT_W-1:0];
  assign rep_len_s    = imem_rdata[CNT_W +: BODY_W];
  assign push_end_s   = pc_r + ADDR_W'(rep_len_s);

  // Read out the top-of-stack loop entry
  always_comb begin
    top_start_s = {ADDR_W{1'b0}};
    top_end_s   = {ADDR_W{1'b0}};
    top_rem_s   = {CNT_W{1'b0}};
    for (int i = 0; i < LOOP_DEPTH; i++) begin
      if (SP_W'(i) == top_idx_s) begin
        top_start_s = lp_start_r[i];
        top_end_s   = lp_end_r[i];
        top_rem_s   = lp_rem_r[i];
      end else begin
        top_rem_s = top_rem_s;
      end
    end
  end

  // Advance rule: only the innermost loop end is compared against pc
  always_comb begin
    adv_pc_s  = pc_r + PC_ONE;
    adv_pop_s = 1'b0;
    adv_dec_s = 1'b0;
    if (top_valid_s && (pc_r == top_end_s)) begin
      if (top_rem_s > CNT_ONE) begin
        adv_dec_s = 1'b1;
        adv_pc_s  = top_start_s;
      end else begin
        adv_pop_s = 1'b1;
      end
    end else begin
      adv_pop_s = 1'b0;
    end
  end

  // Loop stack storage and pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_r <= {SP_W{1'b0}};
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        lp_start_r[i] <= {ADDR_W{1'b0}};
        lp_end_r[i]   <= {ADDR_W{1'b0}};
        lp_rem_r[i]   <= {CNT_W{1'b0}};
      end
    end else if (clear_s) begin
      sp_r <= {SP_W{1'b0}};
    end else if (push_s) begin
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        if (SP_W'(i) == sp_r) begin
          lp_start_r[i] <= pc_r + PC_ONE;
          lp_end_r[i]   <= push_end_s;
          lp_rem_r[i]   <= rep_cnt_s;
        end
      end
      sp_r <= sp_r + SP_ONE;
    end else if (advance_s && adv_pop_s) begin
      sp_r <= sp_r - SP_ONE;
    end else if (advance_s && adv_dec_s) begin
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        if (SP_W'(i) == top_idx_s) begin
          lp_rem_r[i] <= top_rem_s - CNT_ONE;
        end
      end
    end
  end
`else
  // Without loop support the advance rule is a plain increment
  always_comb begin
    adv_pc_s = pc_r + PC_ONE;
  end
`endif

  // Next state, next pc and loop-stack requests
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    latch_s = 1'b0;
`ifdef INST_SEQ_REPEAT_EN
    clear_s   = 1'b0;
    advance_s = 1'b0;
    push_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (start) begin
          state_s = ST_FETCH;
          pc_s    = start_addr;
`ifdef INST_SEQ_REPEAT_EN
          clear_s = 1'b1;
`endif
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode_s)
          OP_NOP: begin
            state_s = ST_FETCH;
            pc_s    = adv_pc_s;
`ifdef INST_SEQ_REPEAT_EN
            advance_s = 1'b1;
`endif
          end
          OP_HALT: begin
            state_s = ST_HALTED;
          end
          OP_JUMP: begin
            state_s = ST_FETCH;
            pc_s    = imem_rdata[ADDR_W-1:0];
          end
`ifdef INST_SEQ_REPEAT_EN
          OP_REPEAT: begin
            if ((rep_cnt_s == {CNT_W{1'b0}}) || (rep_len_s == {BODY_W{1'b0}})) begin
              state_s = ST_FETCH;
              pc_s    = pc_r + PC_ONE + ADDR_W'(rep_len_s);
            end else if (stack_full_s || (top_valid_s && (push_end_s >= top_end_s))) begin
              state_s = ST_ERROR;
            end else begin
              state_s = ST_FETCH;
              pc_s    = pc_r + PC_ONE;
              push_s  = 1'b1;
            end
          end
`endif
          default: begin
            if (opcode_s <= OP_LAST_COMPUTE) begin
              state_s = ST_DISPATCH;
              latch_s = 1'b1;
            end else begin
              state_s = ST_ERROR;
            end
          end
        endcase
      end
      ST_DISPATCH: begin
        if (dispatch_ready) begin
          state_s = ST_FETCH;
          pc_s    = adv_pc_s;
`ifdef INST_SEQ_REPEAT_EN
          advance_s = 1'b1;
`endif
        end else begin
          state_s = ST_DISPATCH;
        end
      end
      default: begin
        state_s = ST_ERROR;
      end
    endcase
  end

  // State, pc and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      pc_r           <= {ADDR_W{1'b0}};
      imem_rd_en     <= 1'b0;
      imem_addr      <= {ADDR_W{1'b0}};
      dispatch_valid <= 1'b0;
      dispatch_inst  <= {INST_W{1'b0}};
      busy           <= 1'b0;
      halted         <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      imem_rd_en     <= (state_s == ST_FETCH);
      if (state_s == ST_FETCH) begin
        imem_addr <= pc_s;
      end
      dispatch_valid <= (state_s == ST_DISPATCH);
      if (latch_s) begin
        dispatch_inst <= imem_rdata;
      end
      busy   <= (state_s == ST_FETCH) || (state_s == ST_DECODE) || (state_s == ST_DISPATCH);
      halted <= (state_s == ST_HALTED);
      error  <= (state_s == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed programs plus random programs, all
// checked against an ISA-level interpreter of the instruction set.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = 12'd0;
  logic        imem_rd_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dispatch_valid;
  logic [31:0] dispatch_inst;
  logic        dispatch_ready = 1'b0;
  logic        busy;
  logic        halted;
  logic        error;

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_addr     (start_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .dispatch_valid (dispatch_valid),
    .dispatch_inst  (dispatch_inst),
    .dispatch_ready (dispatch_ready),
    .busy           (busy),
    .halted         (halted),
    .error          (error)
  );

  logic [31:0] mem [4096];

  // one-cycle-latency instruction memory
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  int    total = 0;
  int    bad = 0;
  string cur_test = "";

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s/%s got=%0h exp=%0h", cur_test, tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int operand);
    logic [31:0] o;
    logic [31:0] d;
    o = op;
    d = operand;
    return {o[3:0], d[27:0]};
  endfunction

  function automatic logic [31:0] rep(input int c, input int l);
    return enc(10, (l << 16) | c);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = enc(9, 0);
  endtask

  // ---------------- reference interpreter ----------------
  typedef struct { int s; int e; int rem; } loop_t;
  loop_t       m_stk[$];
  logic [31:0] exp_words[$];
  int          exp_fetch[$];
  int          exp_ndec;
  bit          exp_halt;
  bit          exp_err;

  function automatic int model_adv(input int pc);
    loop_t t;
    if (m_stk.size() > 0) begin
      t = m_stk[m_stk.size()-1];
      if (t.e == pc) begin
        if (t.rem > 1) begin
          t.rem = t.rem - 1;
          m_stk[m_stk.size()-1] = t;
          return t.s;
        end
        void'(m_stk.pop_back());
      end
    end
    return (pc + 1) % 4096;
  endfunction

  function automatic void model_run(input int sa);
    int pc;
    int op;
    int c;
    int l;
    int e;
    int steps;
    bit done;
    logic [31:0] w;
    loop_t t;
    m_stk.delete();
    exp_words.delete();
    exp_fetch.delete();
    exp_ndec = 0;
    exp_halt = 0;
    exp_err  = 0;
    pc = sa;
    done = 0;
    steps = 0;
    while (!done && steps < 3000) begin
      steps++;
      exp_fetch.push_back(pc);
      w = mem[pc];
      op = int'(w[31:28]);
      exp_ndec++;
      case (op)
        0: pc = model_adv(pc);
        9: begin exp_halt = 1; done = 1; end
        11: pc = int'(w[11:0]);
        10: begin
`ifdef INST_SEQ_REPEAT_EN
          c = int'(w[15:0]);
          l = int'(w[23:16]);
          if (c == 0 || l == 0) begin
            pc = (pc + 1 + l) % 4096;
          end else begin
            e = (pc + l) % 4096;
            if (m_stk.size() == 4 || (m_stk.size() > 0 && e >= m_stk[m_stk.size()-1].e)) begin
              exp_err = 1;
              done = 1;
            end else begin
              t.s = (pc + 1) % 4096;
              t.e = e;
              t.rem = c;
              m_stk.push_back(t);
              pc = (pc + 1) % 4096;
            end
          end
`else
          exp_err = 1;
          done = 1;
`endif
        end
        default: begin
          if (op >= 1 && op <= 8) begin
            exp_words.push_back(w);
            pc = model_adv(pc);
          end else begin
            exp_err = 1;
            done = 1;
          end
        end
      endcase
    end
  endfunction

  // ---------------- program runner ----------------
  task automatic run_prog(input string name, input int sa, input int first_stall, input int max_stall);
    int stalls[$];
    int exp_cyc;
    int cyc = 0;
    int fetch_i = 0;
    int disp_i = 0;
    int hold = 0;
    int st;
    bit fin = 0;
    cur_test = name;
    model_run(sa);
    exp_cyc = 2 * exp_ndec;
    for (int k = 0; k < exp_words.size(); k++) begin
      st = (k == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(0, max_stall));
      stalls.push_back(st);
      exp_cyc += 1 + st;
    end
    @(negedge clk);
    start_addr = sa[11:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_error_clr", error, 0);
    check_val("start_halted_clr", halted, 0);
    while (!fin) begin
      if (imem_rd_en) begin
        if (fetch_i < exp_fetch.size()) check_val("fetch_addr", imem_addr, exp_fetch[fetch_i]);
        else check_val("fetch_count", fetch_i + 1, exp_fetch.size());
        fetch_i++;
      end
      if (dispatch_valid) begin
        check_val("fetch_while_valid", imem_rd_en, 0);
        if (disp_i < exp_words.size()) check_val("dispatch_word", dispatch_inst, exp_words[disp_i]);
        else check_val("dispatch_count", disp_i + 1, exp_words.size());
        hold++;
        st = (disp_i < stalls.size()) ? stalls[disp_i] : 0;
        if (hold > st) begin
          dispatch_ready = 1'b1;
          hold = 0;
          disp_i++;
        end else begin
          dispatch_ready = 1'b0;
        end
      end else begin
        dispatch_ready = 1'($urandom_range(0, 1));
      end
      if (halted || error) begin
        fin = 1;
      end else if (cyc >= exp_cyc + 20) begin
        check_val("timeout_cycles", cyc, exp_cyc);
        fin = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check_val("cycles", cyc, exp_cyc);
    check_val("halted", halted, exp_halt);
    check_val("error", error, exp_err);
    check_val("busy_end", busy, 0);
    check_val("valid_end", dispatch_valid, 0);
    check_val("n_dispatch", disp_i, exp_words.size());
    check_val("n_fetch", fetch_i, exp_fetch.size());
  endtask

  task automatic check_reset_outputs();
    check_val("rst_rd_en", imem_rd_en, 0);
    check_val("rst_addr", imem_addr, 0);
    check_val("rst_valid", dispatch_valid, 0);
    check_val("rst_inst", dispatch_inst, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_error", error, 0);
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = enc(1, 28'h1234567);
    mem[1] = enc(0, 28'h0000055);
    mem[2] = enc(4, 28'h0ABCDEF);
    mem[3] = enc(9, 0);
  endtask

  initial begin
    int sa;
    int w;
    int n;
    int r;
    int a;
    int v;

    // reset values
    cur_test = "reset";
    clear_mem();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_busy", busy, 0);

    load_basic();
    run_prog("basic", 0, 0, 0);

    clear_mem();
    mem[5] = rep(3, 2);
    mem[6] = enc(1, 28'h0000606);
    mem[7] = enc(2, 28'h0000707);
    mem[8] = enc(9, 0);
    run_prog("repeat", 5, -1, 1);

    clear_mem();
    mem[0] = rep(2, 3);
    mem[1] = rep(2, 1);
    mem[2] = enc(1, 28'h0000222);
    mem[3] = enc(3, 28'h0000333);
    mem[4] = enc(9, 0);
    run_prog("nested", 0, -1, 2);

    mem[1] = rep(2, 2);
    run_prog("shared_end", 0, -1, 0);

    clear_mem();
    mem[12'h020] = enc(1, 28'h00000AA);
    mem[12'h021] = enc(5, 28'h00000BB);
    mem[12'h022] = enc(9, 0);
    run_prog("stall5", 12'h020, 5, 0);

    clear_mem();
    mem[12'h100] = enc(11, 12'hFFF);
    mem[12'hFFF] = enc(0, 0);
    mem[0]       = enc(9, 0);
    run_prog("jump_wrap", 12'h100, -1, 0);

    clear_mem();
    mem[12'h010] = enc(1, 28'h0000001);
    mem[12'h011] = enc(13, 0);
    run_prog("illegal_op", 12'h010, -1, 0);

    load_basic();
    run_prog("restart", 0, -1, 2);

    clear_mem();
    mem[12'h030] = rep(1, 10);
    mem[12'h031] = rep(1, 8);
    mem[12'h032] = rep(1, 6);
    mem[12'h033] = rep(1, 4);
    mem[12'h034] = rep(1, 2);
    for (int i = 12'h035; i <= 12'h03A; i++) mem[i] = enc(6, i);
    run_prog("overflow", 12'h030, -1, 0);

    // reset while a dispatch is pending
    cur_test = "rst_dispatch";
    clear_mem();
    mem[12'h040] = enc(1, 28'h0ABCDEF);
    mem[12'h041] = enc(9, 0);
    dispatch_ready = 1'b0;
    @(negedge clk);
    start_addr = 12'h040;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!dispatch_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_val("wait_valid", dispatch_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", busy, 0);

    load_basic();
    run_prog("after_reset", 0, -1, 1);

    for (int t = 0; t < 25; t++) begin
      clear_mem();
      sa = $urandom_range(0, 300);
      n = $urandom_range(6, 16);
      for (int i = 0; i < n; i++) begin
        a = sa + i;
        r = $urandom_range(0, 99);
        v = int'($urandom());
        if (r < 45)      mem[a] = enc($urandom_range(1, 8), v);
        else if (r < 60) mem[a] = enc(0, v);
        else if (r < 80) mem[a] = rep($urandom_range(0, 3), $urandom_range(0, 4));
        else if (r < 92) mem[a] = enc(11, a + 1 + int'($urandom_range(0, 3)));
        else if (r < 96) mem[a] = enc($urandom_range(12, 15), v);
        else             mem[a] = enc(9, v);
      end
      mem[sa + n] = enc(9, 0);
      run_prog($sformatf("random%0d", t), sa, -1, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
